// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the load/store unit.
// master : drives bus_req, bus_we, bus_addr, bus_be and bus_wdata; samples bus_rdata and bus_ack.
// slave  : the data memory, the mirror image of master.
interface mem_access_unit_if #(
    parameter int addr_width = 32,
    parameter int data_width = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [addr_width-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [data_width-1:0] bus_wdata;
    logic [data_width-1:0] bus_rdata;
    logic                  bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store front end between the execute stage and data memory.
// Checks alignment, builds the word address, byte enables and lane-replicated
// store data, runs a req/ack handshake with an ack timeout and returns load
// data right-justified and zero-filled.
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_valid/we/size/addr/wdata     core request, held stable while stall=1
//   stall                            combinational pipeline freeze
//   done, misaligned, bus_timeout    one-cycle status pulses
//   rd_data                          load result for the load-extension block
//   bus                              memory bus (master side)
//
// state  | meaning
// IDLE   | waiting for a request; misaligned requests are answered here
// ACCESS | bus_req high, waiting for bus_ack or the timeout
// RESP   | done pulse, core released
module mem_access_unit #(
    parameter int data_width     = 32,
    parameter int addr_width     = 32,
    parameter int timeout_cycles = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic [addr_width-1:0] req_addr,
    input  logic [data_width-1:0] req_wdata,
    output logic                  stall,
    output logic                  done,
    output logic [data_width-1:0] rd_data,
    output logic                  misaligned,
    output logic                  bus_timeout,
    mem_access_unit_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] timeout_limit = 8'(timeout_cycles);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [addr_width-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [data_width-1:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [data_width-1:0] rd_data_q, rd_data_d;
    logic                  done_q, done_d;
    logic                  misaligned_q, misaligned_d;
    logic                  bus_timeout_q, bus_timeout_d;

    logic                  req_misaligned;
    logic [3:0]            req_be;
    logic [data_width-1:0] req_wdata_rep;
    logic [data_width-1:0] load_shifted;
    logic [data_width-1:0] load_data;

    // Request decode; size 3 behaves exactly like a word access.
    always_comb begin
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_wdata_rep  = req_wdata;
        case (req_size)
            2'd0: begin
                req_be        = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_misaligned = req_addr[0];
                req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep  = {2{req_wdata[15:0]}};
            end
            default: begin
                req_misaligned = (req_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Load data is shifted down to bit 0, then bytes outside the access are cleared.
    always_comb begin
        load_shifted = bus.bus_rdata >> {addr_lo_q, 3'b000};
        case (size_q)
            2'd0:    load_data = {{(data_width-8){1'b0}}, load_shifted[7:0]};
            2'd1:    load_data = {{(data_width-16){1'b0}}, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        size_d        = size_q;
        addr_lo_d     = addr_lo_q;
        rd_data_d     = rd_data_q;
        done_d        = 1'b0;
        misaligned_d  = 1'b0;
        bus_timeout_d = 1'b0;
        stall         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_misaligned) begin
                        misaligned_d = 1'b1;
                        done_d       = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[addr_width-1:2], 2'b00};
                        bus_be_d    = req_be;
                        bus_wdata_d = req_wdata_rep;
                        size_d      = req_size;
                        addr_lo_d   = req_addr[1:0];
                        cnt_d       = 8'd1;
                        state_d     = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                stall = 1'b1;
                // An ack on the last allowed cycle takes priority over the timeout.
                if (bus.bus_ack) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!bus_we_q) begin
                        rd_data_d = load_data;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == timeout_limit) begin
                    bus_req_d     = 1'b0;
                    rd_data_d     = '0;
                    bus_timeout_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            size_q        <= '0;
            addr_lo_q     <= '0;
            rd_data_q     <= '0;
            done_q        <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            size_q        <= size_d;
            addr_lo_q     <= addr_lo_d;
            rd_data_q     <= rd_data_d;
            done_q        <= done_d;
            misaligned_q  <= misaligned_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign done          = done_q;
    assign misaligned    = misaligned_q;
    assign bus_timeout   = bus_timeout_q;
    assign rd_data       = rd_data_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Multi-cycle load/store front end between the execute stage and the data-memory bus. Takes one load or store request from the core, checks alignment, generates the word address, byte enables and lane-replicated write data, and holds a req/ack handshake with memory, stalling the core until done. For loads it returns the accessed byte/half/word right-justified and zero-filled. The downstream load-extension block then applies the sign or zero extension.

Parameters:
data_width, 32, data bus width; fixed at 32 because byte enables are 4 bits.
addr_width, 32, byte address width.
timeout_cycles, 16, maximum cycles spent in ACCESS waiting for bus_ack; must be 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  core request present; held stable by the core while stall=1.
req_we  input  1  1=store, 0=load.
req_size  input  2  0=byte, 1=half, 2=word, 3=treated as word.
req_addr  input  addr_width  byte address.
req_wdata  input  data_width  store data, right-justified.
stall  output  1  freezes the core pipeline.
done  output  1  one-cycle completion pulse.
rd_data  output  data_width  load result, right-justified and zero-filled; feeds the load-extension block.
misaligned  output  1  one-cycle pulse on an alignment fault.
bus_timeout  output  1  one-cycle pulse when the ack window expires.
bus_req  output  1  memory request, registered.
bus_we  output  1  memory write enable.
bus_addr  output  addr_width  word address {req_addr[addr_width-1:2],2'b00}.
bus_be  output  4  byte enables.
bus_wdata  output  data_width  lane-replicated write data.
bus_rdata  input  data_width  memory read data, valid with bus_ack.
bus_ack  input  1  memory completion.

Behaviour:
- Reset (async): state=IDLE. All outputs 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, rd_data, done, misaligned, bus_timeout. Timeout counter=0.
- Reset asserted mid-ACCESS: bus_req drops immediately; the transaction is abandoned; no done pulse.
- Alignment fault: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<(2*addr[1]); word = 4'b1111.
- Write data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- IDLE, req_valid=1 and misaligned:
  - stall=0 combinationally.
  - Next cycle misaligned=1 and done=1 for one cycle.
  - No bus activity; rd_data unchanged; state stays IDLE.
- IDLE, req_valid=1 and aligned:
  - stall=1 combinationally.
  - Next edge: latch address, size, we, be and wdata; drive bus_* from these registers; bus_req=1; counter=1; go to ACCESS.
- ACCESS:
  - stall=1; bus_* held stable.
  - bus_ack=1 on a load: rd_data <= bus_rdata >> (8*addr[1:0]), upper bits 0.
  - bus_ack=1 on a store: rd_data unchanged.
  - bus_ack=1 (either type): bus_req <= 0; go to RESP.
  - bus_ack=0 and counter==timeout_cycles: bus_req <= 0; rd_data <= 0; bus_timeout pulse; go to RESP.
  - bus_ack=0 otherwise: counter increments.
  - bus_ack in the same cycle the counter reaches its limit: ack wins, no timeout.
- RESP: done=1 and stall=0 for one cycle; the request is not re-sampled; go to IDLE.
- Latency: with ack on the first ACCESS cycle, a request accepted at edge N gives done at cycle N+2. Back-to-back requests are spaced by at least 3 cycles.
- bus_ack outside ACCESS is ignored.

Test Plan:
1. Word load, addr 0x100, ack on the first ACCESS cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=1111, rd_data=0xDEADBEEF, done exactly 2 cycles after acceptance.
2. Byte load, addr 0x103, bus_rdata=0x80FF1234 -> bus_be=1000, rd_data=0x00000080. Half load, addr 0x102, same rdata -> bus_be=1100, rd_data=0x000080FF.
3. Byte store, addr 0x201, wdata=0x000000A5 -> bus_we=1, bus_be=0010, bus_wdata=0xA5A5A5A5; rd_data keeps its prior value.
4. Word load at 0x102 and half load at 0x101 -> misaligned and done pulse once each, bus_req never asserted.
5. Never ack, timeout_cycles=4 -> bus_req high exactly 4 cycles, then a bus_timeout pulse, then done, rd_data=0. Ack on cycle 4 -> normal completion, no timeout.
6. Assert rst two cycles into ACCESS -> bus_req=0 immediately, all outputs 0, no done; a new word load afterwards completes normally.
